// File: rtl/cond_sum_subtractor_pipe_if.sv
// Operand/result stream bundle for the pipelined conditional-sum subtractor.
// Both streams use valid/ready: a transfer happens on a rising edge where valid && ready.
interface cond_sum_subtractor_pipe_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x;
    logic [7:0] y;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] d;
    logic       bout;
    logic       ovf;
    logic       zero;

    modport master (
        output in_valid, x, y, bin, out_ready,
        input  in_ready, out_valid, d, bout, ovf, zero
    );

    modport slave (
        input  in_valid, x, y, bin, out_ready,
        output in_ready, out_valid, d, bout, ovf, zero
    );
endinterface

// File: rtl/cond_sum_subtractor_pipe.sv
// Two-stage 8-bit conditional-sum subtractor: S1 resolves the low nibble and both
// high-nibble candidates, S2 selects on the low borrow and registers the flags.
module cond_sum_subtractor_pipe (
    input  logic                          clk,
    input  logic                          rst_n,
    cond_sum_subtractor_pipe_if.slave     bus
);

    logic       s1_v;
    logic [3:0] s1_lo;
    logic       s1_b4;
    logic [3:0] s1_hi0;
    logic [3:0] s1_hi1;
    logic       s1_b8_0;
    logic       s1_b8_1;
    logic       s1_x7;
    logic       s1_y7;

    logic       s2_v;
    logic [7:0] s2_d;
    logic       s2_bout;
    logic       s2_ovf;
    logic       s2_zero;

    logic       s1_load;
    logic       s2_load;
    logic       in_ready_int;

    logic [4:0] lo_diff;
    logic [4:0] hi_diff0;
    logic [4:0] hi_diff1;

    logic [7:0] d_sel;
    logic       bout_sel;
    logic       ovf_sel;
    logic       zero_sel;

    // 5-bit differences: bit 4 is the nibble borrow (set whenever the result went negative).
    assign lo_diff  = {1'b0, bus.x[3:0]} - {1'b0, bus.y[3:0]} - {4'b0000, bus.bin};
    assign hi_diff0 = {1'b0, bus.x[7:4]} - {1'b0, bus.y[7:4]};
    assign hi_diff1 = {1'b0, bus.x[7:4]} - {1'b0, bus.y[7:4]} - 5'd1;

    assign in_ready_int = !s1_v || !s2_v || bus.out_ready;
    assign s1_load      = bus.in_valid && in_ready_int;
    assign s2_load      = s1_v && (!s2_v || bus.out_ready);

    always_comb begin
        d_sel    = {(s1_b4 ? s1_hi1 : s1_hi0), s1_lo};
        bout_sel = s1_b4 ? s1_b8_1 : s1_b8_0;
        ovf_sel  = (s1_x7 != s1_y7) && (d_sel[7] != s1_x7);
        zero_sel = (d_sel == 8'h00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_lo   <= 4'h0;
            s1_b4   <= 1'b0;
            s1_hi0  <= 4'h0;
            s1_hi1  <= 4'h0;
            s1_b8_0 <= 1'b0;
            s1_b8_1 <= 1'b0;
            s1_x7   <= 1'b0;
            s1_y7   <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_v    <= 1'b1;
                s1_lo   <= lo_diff[3:0];
                s1_b4   <= lo_diff[4];
                s1_hi0  <= hi_diff0[3:0];
                s1_hi1  <= hi_diff1[3:0];
                s1_b8_0 <= hi_diff0[4];
                s1_b8_1 <= hi_diff1[4];
                s1_x7   <= bus.x[7];
                s1_y7   <= bus.y[7];
            end else if (s2_load) begin
                s1_v <= 1'b0;
            end
        end
    end

    // S2 data only changes on a load, so a stalled result holds stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_d    <= 8'h00;
            s2_bout <= 1'b0;
            s2_ovf  <= 1'b0;
            s2_zero <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_v    <= 1'b1;
                s2_d    <= d_sel;
                s2_bout <= bout_sel;
                s2_ovf  <= ovf_sel;
                s2_zero <= zero_sel;
            end else if (bus.out_ready) begin
                s2_v <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = s2_v;
    assign bus.d         = s2_d;
    assign bus.bout      = s2_bout;
    assign bus.ovf       = s2_ovf;
    assign bus.zero      = s2_zero;

endmodule

// File: tb/tb_cond_sum_subtractor_pipe.sv
// Bench for cond_sum_subtractor_pipe: arithmetic reference model with an expected
// queue checked on every output transfer, plus literal vectors and flow-control checks.
module tb_cond_sum_subtractor_pipe;

  logic clk;
  logic rst_n;
  int   cyc;

  cond_sum_subtractor_pipe_if bus ();

  cond_sum_subtractor_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters / helpers ----------------
  int checks;
  int passes;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else passes++;
  endtask

  // Reference: plain integer arithmetic. Result packed as {d, bout, ovf, zero}.
  function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b, input logic c);
    int u;
    int s;
    logic [7:0] dd;
    u  = int'(a) - int'(b) - int'(c);
    s  = int'($signed(a)) - int'($signed(b)) - int'(c);
    dd = u[7:0];
    return {dd, (u < 0), ((s < -128) || (s > 127)), (dd == 8'h00)};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [10:0] exp_q[$];
  logic [7:0]  got_d[$];
  int          got_cyc[$];
  logic        stalled;
  logic [10:0] prev_out;

  initial stalled = 1'b0;

  always @(negedge clk) begin
    logic [10:0] e;
    logic [10:0] cur;
    cur = {bus.d, bus.bout, bus.ovf, bus.zero};
    if (!rst_n) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", 32'(cur), 32'(prev_out));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_output", 32'(cur), 32'h7FF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("model_d",    32'(bus.d),    32'(e[10:3]));
          chk("model_bout", 32'(bus.bout), 32'(e[2]));
          chk("model_ovf",  32'(bus.ovf),  32'(e[1]));
          chk("model_zero", 32'(bus.zero), 32'(e[0]));
        end
        got_d.push_back(bus.d);
        got_cyc.push_back(cyc);
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.x, bus.y, bus.bin));
      stalled  = bus.out_valid && !bus.out_ready;
      prev_out = cur;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c);
    int t;
    bus.in_valid = 1'b1;
    bus.x        = a;
    bus.y        = b;
    bus.bin      = c;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Waits (bounded) for a presented result and compares it against literal values.
  task automatic expect_out(input string name, input logic [7:0] ed, input logic eb,
                            input logic eo, input logic ez);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.out_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, "_d"},     32'(bus.d),    32'(ed));
    chk({name, "_bout"},  32'(bus.bout), 32'(eb));
    chk({name, "_ovf"},   32'(bus.ovf),  32'(eo));
    chk({name, "_zero"},  32'(bus.zero), 32'(ez));
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] vx[6];
  logic [7:0] vy[6];
  logic       vb[6];
  logic [7:0] seq_exp[5];
  int         base;
  int         n_before;

  initial begin
    checks = 0;
    passes = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x         = 8'h00;
    bus.y         = 8'h00;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_d",         32'(bus.d),         32'd0);
    chk("rst_flags",     32'({bus.bout, bus.ovf, bus.zero}), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Model pinned by literal expectations
    chk("model_pin_basic", 32'(model(8'h05, 8'h03, 1'b0)), 32'({8'h02, 3'b000}));
    chk("model_pin_ovf",   32'(model(8'h80, 8'h01, 1'b0)), 32'({8'h7F, 3'b010}));
    chk("model_pin_bsel",  32'(model(8'h10, 8'h0F, 1'b1)), 32'({8'h00, 3'b001}));

    // Basic subtract with latency check
    send(8'h05, 8'h03, 1'b0);
    chk("latency_not_early", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("latency_one_edge", 32'(bus.out_valid), 32'd1);
    chk("basic_d", 32'(bus.d), 32'h02);
    chk("basic_flags", 32'({bus.bout, bus.ovf, bus.zero}), 32'b000);
    drain(2);

    send(8'h00, 8'h01, 1'b0);
    expect_out("wrap", 8'hFF, 1'b1, 1'b0, 1'b0);
    drain(2);
    send(8'h80, 8'h01, 1'b0);
    expect_out("sovf", 8'h7F, 1'b0, 1'b1, 1'b0);
    drain(2);
    send(8'h10, 8'h0F, 1'b1);
    expect_out("bsel_zero", 8'h00, 1'b0, 1'b0, 1'b1);
    drain(2);
    send(8'h00, 8'h00, 1'b1);
    expect_out("bsel_all", 8'hFF, 1'b1, 1'b0, 1'b0);
    drain(2);

    // Extra corner vectors streamed back-to-back, checked by the model only
    vx[0] = 8'h7F; vy[0] = 8'hFF; vb[0] = 1'b1;
    vx[1] = 8'h80; vy[1] = 8'h00; vb[1] = 1'b1;
    vx[2] = 8'h00; vy[2] = 8'h80; vb[2] = 1'b0;
    vx[3] = 8'h00; vy[3] = 8'h80; vb[3] = 1'b1;
    vx[4] = 8'hFF; vy[4] = 8'hFF; vb[4] = 1'b0;
    vx[5] = 8'h3C; vy[5] = 8'hA7; vb[5] = 1'b1;
    for (int i = 0; i < 6; i++) send(vx[i], vy[i], vb[i]);
    drain(4);

    // Backpressure stream
    n_before = got_d.size();
    bus.out_ready = 1'b1;
    send(8'h0A, 8'h01, 1'b0);
    bus.out_ready = 1'b0;
    send(8'h0B, 8'h01, 1'b0);
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    fork
      begin
        send(8'h0C, 8'h01, 1'b0);
        send(8'h0D, 8'h01, 1'b0);
        send(8'h0E, 8'h01, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_comb", 32'(bus.in_ready), 32'd1);
      end
    join
    drain(4);
    seq_exp[0] = 8'h09; seq_exp[1] = 8'h0A; seq_exp[2] = 8'h0B;
    seq_exp[3] = 8'h0C; seq_exp[4] = 8'h0D;
    chk("bp_count", 32'(got_d.size() - n_before), 32'd5);
    if (got_d.size() - n_before == 5) begin
      base = n_before;
      for (int i = 0; i < 5; i++) chk("bp_order", 32'(got_d[base + i]), 32'(seq_exp[i]));
      chk("bp_throughput", 32'(got_cyc[base + 4] - got_cyc[base]), 32'd4);
    end

    // Reset mid-flight
    bus.out_ready = 1'b0;
    send(8'h20, 8'h01, 1'b0);
    send(8'h21, 8'h01, 1'b0);
    chk("mid_buffered", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_d",         32'(bus.d),         32'd0);
    chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    n_before = got_d.size();
    drain(5);
    chk("mid_no_stale", 32'(got_d.size() - n_before), 32'd0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/cond_sum_subtractor_pipe.md
# cond_sum_subtractor_pipe

Two-stage pipelined 8-bit conditional-sum subtractor with borrow-in/borrow-out and a valid/ready stream handshake. It is the subtract-direction counterpart of the team's 8-bit conditional-sum adder. It computes x − y − bin using the same split-and-select structure: the low nibble is resolved first, and the high nibble is precomputed for both possible borrows and selected later. It feeds ALU and compare paths that need registered differences and flags at one result per cycle under backpressure.

## Interface
- No parameters; datapath width is fixed at 8 bits (two 4-bit groups).
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand presented
- in_ready  output  1  block can accept operands this cycle
- x  input  8  minuend (unsigned / two's complement)
- y  input  8  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result presented
- out_ready  input  1  consumer accepts result this cycle
- d  output  8  difference, (x − y − bin) mod 256
- bout  output  1  borrow-out: 1 iff x < y + bin (unsigned)
- ovf  output  1  signed overflow: (x[7] != y[7]) && (d[7] != x[7])
- zero  output  1  d == 8'h00

## Operation
- Stage 1 (S1) register captures the following on each accepted transfer (in_valid && in_ready):
  - low-nibble difference d[3:0] and low borrow b4, computed with the actual bin;
  - high-nibble candidates d_hi0/b8_0 (borrow-in 0) and d_hi1/b8_1 (borrow-in 1);
  - x[7] and y[7], kept for the overflow flag;
  - valid bit s1_v.
- Stage 2 (S2) register:
  - selects d[7:4] = b4 ? d_hi1 : d_hi0 and bout = b4 ? b8_1 : b8_0;
  - computes ovf and zero from the selected result;
  - sets valid bit s2_v.
- Outputs d, bout, ovf, zero and out_valid are driven directly from the S2 registers. There is no combinational path from inputs to outputs.
- Flow control:
  - S2 loads when s1_v && (!s2_v || out_ready).
  - S1 loads when in_valid && in_ready.
  - in_ready = !s1_v || !s2_v || out_ready.
- Valid-bit updates:
  - s2_v clears on out_ready when nothing moves in.
  - s1_v clears when S1 moves to S2 with no new input.
- Simultaneous accept at input, S1→S2 move and output drain in one cycle is legal. This is how full throughput is sustained.
- Ordering is strictly FIFO; no transaction is dropped or duplicated.
- While out_valid && !out_ready, the S2 contents (d, bout, ovf, zero) hold stable.
- Input signals are ignored when in_valid = 0.

## Timing
- Reset (rst_n low, asynchronous): s1_v = s2_v = 0, out_valid = 0, d = 8'h00, bout = 0, ovf = 0, zero = 0, and in_ready = 1 (combinational from the cleared valids).
- Latency: a transfer accepted at edge N produces out_valid = 1 with its result after edge N+1 when out_ready was high or S2 was empty.
- Throughput: 1 result per cycle while out_ready = 1.
- Backpressure, out_ready held low:
  - capacity is 2 transactions, one in S1 and one in S2;
  - in_ready falls to 0 after the second accept;
  - in_ready returns to 1 in the same cycle out_ready rises, through the combinational term.
- Reset mid-operation: in-flight transactions are discarded immediately. No stale result appears after rst_n deasserts.
- First accept is possible at the first rising edge after rst_n deasserts.

## Test plan
- Basic subtract: x = 8'h05, y = 8'h03, bin = 0 → d = 8'h02, bout = 0, ovf = 0, zero = 0, out_valid one edge after S1 capture.
- Unsigned wrap: x = 8'h00, y = 8'h01, bin = 0 → d = 8'hFF, bout = 1, ovf = 0, zero = 0.
- Signed overflow: x = 8'h80, y = 8'h01, bin = 0 → d = 8'h7F, bout = 0, ovf = 1.
- Borrow-select path: x = 8'h10, y = 8'h0F, bin = 1 → low nibble borrows (b4 = 1), d = 8'h00, zero = 1, bout = 0. Also x = 8'h00, y = 8'h00, bin = 1 → d = 8'hFF, bout = 1.
- Backpressure stream:
  - stimulus: 5 back-to-back operands ({x, y} = {8'h0A, 8'h01} … {8'h0E, 8'h01}) with out_ready low for 3 cycles mid-stream;
  - required: in_ready drops after two buffered transfers, and outputs hold stable while stalled;
  - required: d sequence 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D in order, no loss or duplication;
  - required: 1 result per cycle once out_ready = 1.
- Reset mid-flight: two transactions buffered, rst_n pulsed low asynchronously → out_valid = 0 and d = 8'h00 immediately, in_ready = 1, no result emitted after release.
